// File: rtl/clock_pkg.sv
// Purpose: shared types and digit-width constants for the mm:ss clock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_pkg;

  // Encoding is visible on the mode output, so the values are fixed.
  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } mode_t;

  localparam int BCD_W     = 4;  // units digit width
  localparam int TENS_W    = 3;  // tens digit width (0..5)
  localparam int TENS_MAX  = 5;
  localparam int UNITS_MAX = 9;

endpackage

// File: rtl/mod60_bcd_inc.sv
// Purpose: {tens,units} BCD increment with wrap 59 -> 00.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: tens/units = current pair; nxt_tens/nxt_units = pair + 1 mod 60.
module mod60_bcd_inc
  import clock_pkg::*;
(
  input  logic [TENS_W-1:0] tens,
  input  logic [BCD_W-1:0]  units,
  output logic [TENS_W-1:0] nxt_tens,
  output logic [BCD_W-1:0]  nxt_units
);

  always_comb begin
    nxt_tens  = tens;
    nxt_units = units + 1'b1;
    if (units == BCD_W'(UNITS_MAX)) begin
      nxt_units = '0;
      nxt_tens  = (tens == TENS_W'(TENS_MAX)) ? '0 : tens + 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Purpose: run/stop/set control for the mm:ss counter: 1 Hz enable, button FSM, shadow edit + load.
// Latency: state/strobe outputs registered, one cycle after the button edge; ld_* follow shadow regs.
// Backpressure: none; presses are single-cycle events and lower-priority ones are dropped.
// Ports: clk/reset; btn_mode/btn_inc/btn_startstop synchronized levels; cur_* live counter digits;
//        tick_en count enable; load + ld_* parallel load; mode = mode_t state; blink edit-field blank.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_startstop,
  input  logic [BCD_W-1:0]  cur_sec_units,
  input  logic [TENS_W-1:0] cur_sec_tens,
  input  logic [BCD_W-1:0]  cur_min_units,
  input  logic [TENS_W-1:0] cur_min_tens,
  output logic              tick_en,
  output logic              load,
  output logic [BCD_W-1:0]  ld_sec_units,
  output logic [TENS_W-1:0] ld_sec_tens,
  output logic [BCD_W-1:0]  ld_min_units,
  output logic [TENS_W-1:0] ld_min_tens,
  output logic [1:0]        mode,
  output logic              blink
);

  localparam int             PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

  mode_t             state, state_nxt;
  logic [PW-1:0]     presc;
  logic              wrap;
  logic              mode_q, inc_q, ss_q;
  logic              mode_p, ss_p, inc_p;
  logic              load_nxt, tick_nxt, blink_nxt;
  logic              in_edit, next_edit;

  logic [TENS_W-1:0] sh_min_tens, sh_sec_tens, min_tens_inc, sec_tens_inc;
  logic [BCD_W-1:0]  sh_min_units, sh_sec_units, min_units_inc, sec_units_inc;

  // Rising-edge detect with one-press-per-cycle priority: mode > startstop > inc.
  assign mode_p = btn_mode & ~mode_q;
  assign ss_p   = btn_startstop & ~ss_q & ~mode_p;
  assign inc_p  = btn_inc & ~inc_q & ~mode_p & ~(btn_startstop & ~ss_q);

  assign wrap      = (presc == PMAX);
  assign in_edit   = (state == SET_MIN) || (state == SET_SEC);
  assign next_edit = (state_nxt == SET_MIN) || (state_nxt == SET_SEC);

  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b0;
    case (state)
      STOPPED: begin
        if (mode_p)    state_nxt = SET_MIN;
        else if (ss_p) state_nxt = RUNNING;
      end
      RUNNING: if (ss_p) state_nxt = STOPPED;
      SET_MIN: if (mode_p) state_nxt = SET_SEC;
      SET_SEC: begin
        if (mode_p) begin
          state_nxt = STOPPED;
          load_nxt  = 1'b1;
        end
      end
      default: state_nxt = STOPPED;
    endcase
    // A stop press on the wrap cycle swallows that tick.
    tick_nxt  = (state == RUNNING) && wrap && !ss_p;
    // Blink restarts at 0 on every entry into editing and toggles per prescaler wrap.
    blink_nxt = (in_edit && next_edit) ? (blink ^ wrap) : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STOPPED;
      presc   <= '0;
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
      ss_q    <= 1'b0;
      tick_en <= 1'b0;
      load    <= 1'b0;
      blink   <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      ss_q    <= btn_startstop;
      tick_en <= tick_nxt;
      load    <= load_nxt;
      blink   <= blink_nxt;
      if (state == STOPPED || wrap) presc <= '0;
      else                          presc <= presc + 1'b1;
    end
  end

  // Shadow digits: snapshot on edit entry, then bumped per field; never carry min<->sec.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_min_tens  <= '0;
      sh_min_units <= '0;
      sh_sec_tens  <= '0;
      sh_sec_units <= '0;
    end else if (state == STOPPED && mode_p) begin
      sh_min_tens  <= cur_min_tens;
      sh_min_units <= cur_min_units;
      sh_sec_tens  <= cur_sec_tens;
      sh_sec_units <= cur_sec_units;
    end else if (state == SET_MIN && inc_p) begin
      sh_min_tens  <= min_tens_inc;
      sh_min_units <= min_units_inc;
    end else if (state == SET_SEC && inc_p) begin
      sh_sec_tens  <= sec_tens_inc;
      sh_sec_units <= sec_units_inc;
    end
  end

  mod60_bcd_inc u_min_inc (
    .tens      (sh_min_tens),
    .units     (sh_min_units),
    .nxt_tens  (min_tens_inc),
    .nxt_units (min_units_inc)
  );

  mod60_bcd_inc u_sec_inc (
    .tens      (sh_sec_tens),
    .units     (sh_sec_units),
    .nxt_tens  (sec_tens_inc),
    .nxt_units (sec_units_inc)
  );

  assign mode         = state;
  assign ld_min_tens  = sh_min_tens;
  assign ld_min_units = sh_min_units;
  assign ld_sec_tens  = sh_sec_tens;
  assign ld_sec_units = sh_sec_units;

endmodule
